imem_stream_loader: RTL

- Byte-addressed instruction memory with a serial byte-stream write port and a combinational 32-bit fetch read port.
- The fetch stage reads from it.
- Loads a length-prefixed, checksummed program image from an external byte source (UART/debug bridge) via valid/ready.
- Holds the core stalled (core_run=0, drives fetch stage PC_write) until an image loads cleanly.

---
 rtl/imem_stream_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_stream_loader.sv
// Byte-addressed instruction memory loaded from a length-prefixed, XOR-checksummed byte stream.
// The core is held stalled through core_run until an image has loaded cleanly.
module imem_stream_loader #(
    parameter int MEM_BYTES = 64,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    input  logic [31:0]      fetch_addr,
    output logic [31:0]      fetch_instr,
    output logic             core_run,
    output logic             load_done,
    output logic             load_err,
    output logic [LEN_W-1:0] words_loaded
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int IW = LEN_W + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_RUN    = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       hdr_hi_q, hdr_hi_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [7:0]       acc_q, acc_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic             s_ready_q, s_ready_d;
    logic             core_run_q, core_run_d;
    logic             load_done_q, load_done_d;
    logic             load_err_q, load_err_d;

    logic [7:0]       mem_q [MEM_BYTES];

    logic             beat_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_addr_s;
    logic [LEN_W-1:0] hdr_len_s;
    logic [IW-1:0]    hdr_bytes_s;
    logic             hdr_bad_s;
    logic [IW-1:0]    n_bytes_s;

    // Header decode: the low length byte arrives on s_data during HDR_LO.
    always_comb begin
        hdr_len_s   = LEN_W'({hdr_hi_q, s_data});
        hdr_bytes_s = {hdr_len_s, 2'b00};
        hdr_bad_s   = (hdr_len_s == {LEN_W{1'b0}}) ||
                      (32'(hdr_bytes_s) > 32'(MEM_BYTES));
        n_bytes_s   = {len_q, 2'b00};
        beat_s      = s_valid & s_ready_q;
        wr_addr_s   = idx_q[AW-1:0];
    end

    // Next-state and datapath for the load sequencer; outputs derive from the next state.
    always_comb begin
        state_d  = state_q;
        hdr_hi_d = hdr_hi_q;
        len_d    = len_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        words_d  = words_q;
        wr_en_s  = 1'b0;
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_d = S_HDR_HI;
                    words_d = {LEN_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_HDR_HI: begin
                if (beat_s) begin
                    hdr_hi_d = s_data;
                    state_d  = S_HDR_LO;
                end else begin
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_LO: begin
                if (beat_s) begin
                    len_d = hdr_len_s;
                    if (hdr_bad_s) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = {IW{1'b0}};
                        acc_d   = 8'h00;
                    end
                end else begin
                    state_d = S_HDR_LO;
                end
            end
            S_DATA: begin
                if (beat_s) begin
                    wr_en_s = 1'b1;
                    acc_d   = acc_q ^ s_data;
                    idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
                    if (idx_q[1:0] == 2'b11) begin
                        words_d = words_q + {{(LEN_W-1){1'b0}}, 1'b1};
                    end else begin
                        words_d = words_q;
                    end
                    if (idx_q == n_bytes_s - {{(IW-1){1'b0}}, 1'b1}) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CSUM: begin
                if (beat_s) begin
                    if (s_data == acc_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = S_CSUM;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        s_ready_d   = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                      (state_d == S_DATA)   || (state_d == S_CSUM);
        core_run_d  = (state_d == S_RUN);
        load_done_d = (state_d == S_RUN);
        load_err_d  = (state_d == S_ERR);
    end

    // Sequencer state, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hdr_hi_q    <= 8'h00;
            len_q       <= {LEN_W{1'b0}};
            idx_q       <= {IW{1'b0}};
            acc_q       <= 8'h00;
            words_q     <= {LEN_W{1'b0}};
            s_ready_q   <= 1'b0;
            core_run_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_hi_q    <= hdr_hi_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            words_q     <= words_d;
            s_ready_q   <= s_ready_d;
            core_run_q  <= core_run_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    // Instruction memory: cleared on reset, written one byte per DATA beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (wr_en_s) begin
                mem_q[wr_addr_s] <= s_data;
            end
        end
    end

    // Big-endian fetch; 33-bit sums keep addresses near 2^32 from wrapping into memory.
    always_comb begin
        logic [32:0] rd_addr;
        fetch_instr = 32'h0000_0000;
        rd_addr     = 33'd0;
        for (int k = 0; k < 4; k++) begin
            rd_addr = {1'b0, fetch_addr} + 33'(k);
            if (rd_addr < 33'(MEM_BYTES)) begin
                fetch_instr[31-8*k -: 8] = mem_q[rd_addr[AW-1:0]];
            end else begin
                fetch_instr[31-8*k -: 8] = 8'h00;
            end
        end
    end

    assign s_ready      = s_ready_q;
    assign core_run     = core_run_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;

endmodule
